kbd_ctrl: RTL and testbench
===========================

Name: kbd_ctrl

Overview:
- PS/2 keyboard receiver serving the 0xe (keyboard) window of the CPU memory map.
- Synchronises and filters the raw PS/2 clock and data lines, deframes 11-bit frames, and queues scan codes in a FIFO.
- Exposes a two-word register interface; cpu_interface muxes rd_data onto dmem_data_out for addresses with dmem_addr[29:26]==4'he.

Parameters:
FIFO_AW, 4, log2 of FIFO depth (16 entries)
FILTER_LEN, 8, consecutive stable ui_clk cycles required before the filtered ps2_clk level changes
TIMEOUT_CYC, 200000, ui_clk cycles without a falling edge before an in-progress frame is aborted

Ports:
ui_clk  input  1  block clock
rst  input  1  reset, synchronous, active-low
ps2_clk  input  1  raw PS/2 clock, asynchronous
ps2_data  input  1  raw PS/2 data, asynchronous
rd_en  input  1  one-cycle read strobe; asserted only when the access targets the 0xe window
rd_addr  input  1  register select: 0 = DATA, 1 = STATUS (dmem_addr[0])
rd_data  output  32  combinational read data for the selected register
data_avail  output  1  FIFO non-empty

Behaviour:
- Reset (rst==0 at a ui_clk edge) has these effects:
  - FIFO is emptied: count 0, pointers 0.
  - FSM goes to IDLE.
  - Sticky flags ovf, perr and ferr are cleared.
  - Filtered clock is set to 1; timeout counter is cleared.
  - data_avail=0; rd_data reads 0 for DATA and 0 for STATUS.
  - A frame in progress is discarded.
- Input conditioning:
  - Each of ps2_clk and ps2_data passes through a 2-FF synchroniser.
  - Filter: the filtered clock takes the synced ps2_clk value once that value has held for FILTER_LEN consecutive cycles.
  - fall = one-cycle pulse on a filtered 1->0 transition.
  - On fall, the bit is sampled from synced ps2_data.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP.
  - IDLE: on fall with bit==0 (start bit), go to DATA with bit counter = 0. On fall with bit==1, stay in IDLE; no flag is set.
  - DATA: on fall, shift right and insert the bit at position 7 (LSB first). After the 8th bit (counter==7), go to PARITY.
  - PARITY: on fall, par_ok = ^{shift, bit} == 1 (odd parity). Go to STOP.
  - STOP: on fall, return to IDLE.
    - If bit==1 and par_ok: push shift into the FIFO.
    - If !par_ok: set perr and do not push.
    - Else if bit==0: set ferr and do not push.
- Timeout:
  - The counter clears on every fall and while in IDLE, and increments otherwise.
  - When it reaches TIMEOUT_CYC-1 outside IDLE, the FSM returns to IDLE, sets ferr and discards the partial byte.
  - A timeout and a fall in the same cycle: the fall wins.
- FIFO:
  - Push while full (without a simultaneous pop): the byte is dropped and ovf is set.
  - Push and pop in the same cycle while full: both take effect; ovf is not set; count is unchanged.
  - Push and pop in the same cycle while empty: only the push occurs.
  - Pointers are FIFO_AW bits and wrap modulo the depth; count is FIFO_AW+1 bits.
- DATA register (rd_addr==0):
  - rd_data = {23'b0, !empty, head[7:0]}; rd_data = 0 when empty.
  - rd_en with rd_addr==0 pops on that edge if non-empty; if empty it has no effect.
- STATUS register (rd_addr==1):
  - rd_data = {21'b0, ferr, perr, ovf, 3'b0, count[4:0]}, i.e. count in bits [4:0], ovf bit 8, perr bit 9, ferr bit 10.
  - Count bits are sized for FIFO_AW=4; wider FIFOs truncate the reported count.
  - rd_en with rd_addr==1 clears ovf, perr and ferr on that edge.
  - If a flag-setting event occurs on the same edge as the clear, the flag ends up set.
- Latency: a scan code appears on rd_data and data_avail on the cycle after the STOP-bit fall is processed (fall itself lags the raw edge by 2 + FILTER_LEN cycles).
- rd_data is purely combinational from the FIFO head and flags; there is no read latency.

Test Plan:
- Reset mid-frame: after start bit + 3 data bits, pull rst=0 for 1 cycle, then send a clean frame for 0x1C -> FIFO holds only 0x1C; DATA reads 0x11C; STATUS reads 0x001.
- Clean frames 0x1C (parity 0) then 0xF0 (parity 1), followed by rd_en@0 twice:
  - First read returns 0x11C, second returns 0x1F0.
  - A third read returns 0x000; data_avail falls after the second pop.
- Parity error: 0x1C sent with parity 1 -> no push; STATUS=0x200. rd_en@1 -> next STATUS read = 0x000.
- Overflow: send 17 frames 0x00..0x10 with no reads -> STATUS=0x110 (count 16, ovf); 16 pops return 0x100..0x10F; 0x10 is lost.
- Glitch/timeout:
  - A 3-cycle low glitch on ps2_clk produces no fall.
  - Stopping the clock after 5 bits for TIMEOUT_CYC cycles -> ferr=1, FSM back in IDLE, and the next clean 0x5A frame is received correctly.
- Simultaneous push and pop with the FIFO full -> count stays 16, ovf stays 0, head advances.

Source files
------------

// File: rtl/kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kbd_ctrl
// Description : PS/2 keyboard receiver with scan-code FIFO and a two-word
//               register interface (DATA / STATUS).
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_ctrl #(
    parameter int FIFO_AW     = 4,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        ui_clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rd_en,
    input  logic        rd_addr,
    output logic [31:0] rd_data,
    output logic        data_avail
);

    localparam int c_DEPTH = 1 << FIFO_AW;
    localparam int c_FLT_W = $clog2(FILTER_LEN + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic               r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic               r_clk_flt, r_clk_flt_d;
    logic [c_FLT_W-1:0] r_flt_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;

    state_t             r_state, w_state_next;
    logic [2:0]         r_bit_cnt, w_bit_cnt_next;
    logic [7:0]         r_shift, w_shift_next;
    logic               r_par_ok, w_par_ok_next;

    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf, r_perr, r_ferr;

    logic               w_fall, w_bit, w_timeout;
    logic               w_push, w_perr_set, w_ferr_set;
    logic               w_full, w_empty, w_pop, w_do_push, w_ovf_set, w_clr;
    logic [4:0]         w_cnt5;

    // Idle PS/2 lines are high, so the synchronisers come out of reset high
    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_clk_flt   <= 1'b1;
            r_clk_flt_d <= 1'b1;
            r_flt_cnt   <= '0;
        end else begin
            r_clk_s1    <= ps2_clk;
            r_clk_s2    <= r_clk_s1;
            r_dat_s1    <= ps2_data;
            r_dat_s2    <= r_dat_s1;
            r_clk_flt_d <= r_clk_flt;
            if (r_clk_s2 == r_clk_flt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == c_FLT_W'(FILTER_LEN - 1)) begin
                r_clk_flt <= r_clk_s2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_fall    = r_clk_flt_d & ~r_clk_flt;
    assign w_bit     = r_dat_s2;
    assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_ok  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_par_ok  <= w_par_ok_next;
            if (w_fall || r_state == S_IDLE) r_to_cnt <= '0;
            else                             r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_par_ok_next  = r_par_ok;
        w_push         = 1'b0;
        w_perr_set     = 1'b0;
        w_ferr_set     = 1'b0;
        if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_bit) begin
                        w_state_next   = S_DATA;
                        w_bit_cnt_next = '0;
                    end
                end
                S_DATA: begin
                    w_shift_next   = {w_bit, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_next = S_PARITY;
                end
                S_PARITY: begin
                    w_par_ok_next = ^{r_shift, w_bit};
                    w_state_next  = S_STOP;
                end
                default: begin
                    w_state_next = S_IDLE;
                    if (!r_par_ok)  w_perr_set = 1'b1;
                    else if (!w_bit) w_ferr_set = 1'b1;
                    else            w_push     = 1'b1;
                end
            endcase
        end else if (w_timeout) begin
            w_state_next = S_IDLE;
            w_ferr_set   = 1'b1;
        end
    end

    // Full is exactly count == depth, i.e. the count MSB alone
    assign w_full     = r_count[FIFO_AW];
    assign w_empty    = (r_count == '0);
    assign w_pop      = rd_en & ~rd_addr & ~w_empty;
    assign w_do_push  = w_push & (~w_full | w_pop);
    assign w_ovf_set  = w_push & w_full & ~w_pop;
    assign w_clr      = rd_en & rd_addr;
    assign data_avail = ~w_empty;

    always_ff @(posedge ui_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A flag raised on the clearing edge survives the clear
            r_ovf  <= (r_ovf  & ~w_clr) | w_ovf_set;
            r_perr <= (r_perr & ~w_clr) | w_perr_set;
            r_ferr <= (r_ferr & ~w_clr) | w_ferr_set;
        end
    end

    generate
        if (FIFO_AW >= 4) begin : g_cnt_trunc
            assign w_cnt5 = r_count[4:0];
        end else begin : g_cnt_ext
            assign w_cnt5 = 5'(r_count);
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        if (rd_addr)       rd_data = {21'b0, r_ferr, r_perr, r_ovf, 3'b0, w_cnt5};
        else if (!w_empty) rd_data = {23'b0, 1'b1, r_mem[r_rd_ptr]};
    end

endmodule
`default_nettype wire

// File: tb/tb_kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kbd_ctrl
// Description : Self-checking bench for kbd_ctrl against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_ctrl;

    localparam int FIFO_AW     = 4;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 300;
    localparam int DEPTH       = 16;
    localparam int H           = 20;

    logic        ui_clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        rd_en = 1'b0;
    logic        rd_addr = 1'b0;
    logic [31:0] rd_data;
    logic        data_avail;

    int total = 0;
    int bad   = 0;

    byte unsigned mq[$];
    bit m_ovf, m_perr, m_ferr;

    kbd_ctrl #(
        .FIFO_AW    (FIFO_AW),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .ui_clk    (ui_clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .data_avail(data_avail)
    );

    always #5 ui_clk = ~ui_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ui_clk);
        #1;
    endtask

    function automatic logic [31:0] exp_data();
        if (mq.size() == 0) return 32'h0;
        return {23'b0, 1'b1, mq[0]};
    endfunction

    function automatic logic [31:0] exp_status();
        return {21'b0, m_ferr, m_perr, m_ovf, 3'b0, 5'(mq.size())};
    endfunction

    function automatic logic [31:0] model_read(input logic a);
        logic [31:0] e;
        if (a) begin
            e = exp_status();
            m_ovf = 0; m_perr = 0; m_ferr = 0;
        end else begin
            e = exp_data();
            if (mq.size() > 0) void'(mq.pop_front());
        end
        return e;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit pflip, input bit stopv);
        if (pflip)                   m_perr = 1;
        else if (!stopv)             m_ferr = 1;
        else if (mq.size() == DEPTH) m_ovf  = 1;
        else                         mq.push_back(b);
    endfunction

    // Frame = start, 8 data LSB first, odd parity (optionally inverted), stop
    task automatic send_frame(input logic [7:0] b, input bit pflip, input bit stopv,
                              input int nbits, input bit pop_at_stop,
                              output logic [31:0] popped);
        logic [10:0] bits;
        bits   = {stopv, (~^b) ^ pflip, b, 1'b0};
        popped = 32'h0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(H);
            ps2_clk = 1'b0;
            if (i == 10 && pop_at_stop) begin
                cyc(2 + FILTER_LEN);
                rd_addr = 1'b0;
                rd_en   = 1'b1;
                #1 popped = rd_data;
                cyc(1);
                rd_en = 1'b0;
                cyc(H - 3 - FILTER_LEN);
            end else begin
                cyc(H);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(H);
        if (nbits == 11) begin
            if (pop_at_stop && mq.size() > 0) void'(mq.pop_front());
            model_frame(b, pflip, stopv);
        end
    endtask

    task automatic peek(input logic a, output logic [31:0] v);
        rd_addr = a;
        #1 v = rd_data;
    endtask

    task automatic rd(input logic a, output logic [31:0] v);
        rd_addr = a;
        rd_en   = 1'b1;
        #1 v = rd_data;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        cyc(4);
        peek(0, v); total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=%h", v, 32'h0); end
        peek(1, v); total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=%h", v, 32'h0); end
        total++;
        if (data_avail !== 1'b0) begin bad++; $display("FAIL reset_avail got=%b exp=0", data_avail); end
        rst = 1'b1;
        cyc(4);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v, d;
        send_frame(8'h33, 0, 1, 11, 0, d);
        send_frame(8'h1C, 0, 1, 4, 0, d);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        mq.delete(); m_ovf = 0; m_perr = 0; m_ferr = 0;
        cyc(5);
        send_frame(8'h1C, 0, 1, 11, 0, d);
        peek(1, v); total++;
        if (v !== 32'h001) begin bad++; $display("FAIL midrst_status got=%h exp=%h", v, 32'h001); end
        peek(0, v); total++;
        if (v !== 32'h11C) begin bad++; $display("FAIL midrst_data got=%h exp=%h", v, 32'h11C); end
        rd(0, v);
        void'(model_read(0));
    endtask

    task automatic test_clean();
        logic [31:0] v, d;
        send_frame(8'h1C, 0, 1, 11, 0, d);
        send_frame(8'hF0, 0, 1, 11, 0, d);
        rd(0, v); void'(model_read(0)); total++;
        if (v !== 32'h11C) begin bad++; $display("FAIL clean_rd1 got=%h exp=%h", v, 32'h11C); end
        total++;
        if (data_avail !== 1'b1) begin bad++; $display("FAIL clean_avail1 got=%b exp=1", data_avail); end
        rd(0, v); void'(model_read(0)); total++;
        if (v !== 32'h1F0) begin bad++; $display("FAIL clean_rd2 got=%h exp=%h", v, 32'h1F0); end
        total++;
        if (data_avail !== 1'b0) begin bad++; $display("FAIL clean_avail2 got=%b exp=0", data_avail); end
        rd(0, v); void'(model_read(0)); total++;
        if (v !== 32'h0) begin bad++; $display("FAIL clean_rd3 got=%h exp=%h", v, 32'h0); end
    endtask

    task automatic test_parity();
        logic [31:0] v, d;
        send_frame(8'h1C, 1, 1, 11, 0, d);
        rd(1, v); void'(model_read(1)); total++;
        if (v !== 32'h200) begin bad++; $display("FAIL parity_status got=%h exp=%h", v, 32'h200); end
        peek(1, v); total++;
        if (v !== 32'h000) begin bad++; $display("FAIL parity_clear got=%h exp=%h", v, 32'h000); end
    endtask

    task automatic test_overflow();
        logic [31:0] v, d;
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 0, 1, 11, 0, d);
        peek(1, v); total++;
        if (v !== 32'h110) begin bad++; $display("FAIL ovf_status got=%h exp=%h", v, 32'h110); end
        for (int i = 0; i < 16; i++) begin
            rd(0, v); void'(model_read(0)); total++;
            if (v !== (32'h100 | 32'(i))) begin
                bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, v, 32'h100 | 32'(i));
            end
        end
        rd(1, v); void'(model_read(1)); total++;
        if (v !== 32'h100) begin bad++; $display("FAIL ovf_after got=%h exp=%h", v, 32'h100); end
    endtask

    task automatic test_glitch_timeout();
        logic [31:0] v, d;
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(30);
        ps2_data = 1'b1;
        cyc(5);
        send_frame(8'hA5, 0, 1, 11, 0, d);
        rd(0, v); void'(model_read(0)); total++;
        if (v !== 32'h1A5) begin bad++; $display("FAIL glitch_data got=%h exp=%h", v, 32'h1A5); end
        send_frame(8'h3C, 0, 1, 5, 0, d);
        cyc(TIMEOUT_CYC + 50);
        m_ferr = 1;
        rd(1, v); void'(model_read(1)); total++;
        if (v !== 32'h400) begin bad++; $display("FAIL timeout_status got=%h exp=%h", v, 32'h400); end
        send_frame(8'h5A, 0, 1, 11, 0, d);
        rd(0, v); void'(model_read(0)); total++;
        if (v !== 32'h15A) begin bad++; $display("FAIL timeout_next got=%h exp=%h", v, 32'h15A); end
        peek(1, v); total++;
        if (v !== 32'h000) begin bad++; $display("FAIL timeout_clean got=%h exp=%h", v, 32'h000); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v, d, e;
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 0, 1, 11, 0, d);
        e = exp_data();
        send_frame(8'hC3, 0, 1, 11, 1, d);
        total++;
        if (d !== e) begin bad++; $display("FAIL b2b_pop got=%h exp=%h", d, e); end
        peek(1, v); total++;
        if (v !== 32'h010) begin bad++; $display("FAIL b2b_status got=%h exp=%h", v, 32'h010); end
        for (int i = 0; i < DEPTH; i++) begin
            e = model_read(0);
            rd(0, v); total++;
            if (v !== e) begin bad++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, v, e); end
        end
        total++;
        if (e !== 32'h1C3) begin bad++; $display("FAIL b2b_last got=%h exp=%h", e, 32'h1C3); end
    endtask

    task automatic test_random();
        logic [31:0] v, d, e;
        logic [7:0]  b;
        int k;
        logic a;
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom_range(0, 255));
            k = $urandom_range(0, 9);
            send_frame(b, k == 8, k != 9, 11, 0, d);
            total++;
            if (data_avail !== (mq.size() > 0)) begin
                bad++; $display("FAIL rand_avail%0d got=%b exp=%b", n, data_avail, mq.size() > 0);
            end
            for (int r = 0; r < int'($urandom_range(0, 2)); r++) begin
                a = 1'($urandom_range(0, 1));
                e = model_read(a);
                rd(a, v); total++;
                if (v !== e) begin bad++; $display("FAIL rand_rd%0d_%0d got=%h exp=%h", n, a, v, e); end
            end
        end
        for (int r = 0; r < 2 + DEPTH; r++) begin
            a = (r == 0) ? 1'b1 : 1'b0;
            e = model_read(a);
            rd(a, v); total++;
            if (v !== e) begin bad++; $display("FAIL rand_drain%0d got=%h exp=%h", r, v, e); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midframe();
        test_clean();
        test_parity();
        test_overflow();
        test_glitch_timeout();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
